// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared constants, id-width helper and result record
// for the shared-adder arbiter (adder_share_arb) and its grant logic.
package adder_share_pkg;

    localparam int MAX_REQ   = 8;
    localparam int MAX_WIDTH = 64;
    localparam int MAX_ID_W  = 3;

    // Requester index width, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [MAX_WIDTH-1:0] sum;
        logic                 cout;
        logic [MAX_ID_W-1:0]  id;
    } result_t;

endpackage

// File: rtl/adder_rr_arb.sv
// adder_rr_arb: stateless round-robin grant selection.
// Ports: req (request vector), ptr (search start index), grant (one-hot).
module adder_rr_arb
    import adder_share_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic           found;
    logic [IDW-1:0] idx;

    // Walk the requesters starting at ptr; the first active one wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: one WIDTH-bit adder shared round-robin by NUM_REQ
// requesters. Ports: clk, rst_n (async, active-low); req_valid/req_ready
// and packed req_a/req_b per requester; rsp_valid/rsp_ready with
// rsp_sum, rsp_cout, rsp_id. Macro ADDER_SHARE_ARB_OUTREG_EN adds a
// registered result stage (latency 2 instead of 1).
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    localparam int IDW     = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [IDW-1:0]           rsp_id
);

    logic [IDW-1:0]     ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     gid;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic               xfer;

    logic               op_v;
    logic               op_free;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [IDW-1:0]     op_id;
    logic [WIDTH:0]     add_full;

    adder_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Only the granted requester's operands reach the operand stage.
    always_comb begin
        gid   = '0;
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gid   = IDW'(i);
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // rst_n gates ready so nothing is accepted while reset is held.
    assign req_ready = grant & {NUM_REQ{op_free & rst_n}};
    assign xfer      = |req_ready;
    assign add_full  = {1'b0, op_a} + {1'b0, op_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (gid == IDW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_v <= 1'b0;
        end else if (xfer) begin
            op_v <= 1'b1;
        end else if (op_free) begin
            op_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            op_a  <= a_sel;
            op_b  <= b_sel;
            op_id <= gid;
        end
    end

`ifdef ADDER_SHARE_ARB_OUTREG_EN

    logic             res_v;
    logic             res_free;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic [IDW-1:0]   res_id;

    // Both stages advance together when the result slot empties,
    // which keeps one result per cycle under rsp_ready=1.
    assign res_free = ~res_v | rsp_ready;
    assign op_free  = ~op_v | res_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_v <= 1'b0;
        end else if (res_free) begin
            res_v <= op_v;
        end
    end

    always_ff @(posedge clk) begin
        if (res_free && op_v) begin
            res_sum  <= add_full[WIDTH-1:0];
            res_cout <= add_full[WIDTH];
            res_id   <= op_id;
        end
    end

    assign rsp_valid = res_v;
    assign rsp_sum   = res_sum;
    assign rsp_cout  = res_cout;
    assign rsp_id    = res_id;

`else

    assign op_free   = ~op_v | rsp_ready;
    assign rsp_valid = op_v;
    assign rsp_sum   = add_full[WIDTH-1:0];
    assign rsp_cout  = add_full[WIDTH];
    assign rsp_id    = op_id;

`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: scoreboard bench for adder_share_arb
// (NUM_REQ=4, WIDTH=32); follows ADDER_SHARE_ARB_OUTREG_EN for latency.
module tb_adder_share_arb;

    localparam int N = 4;
    localparam int W = 32;
`ifdef ADDER_SHARE_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic [1:0]     rsp_id;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic [1:0]   id;
    } exp_t;

    exp_t         exp_q[$];
    int           grant_log[$];
    logic [N-1:0] hs_mask;
    int           n_cmp;
    int           n_fail;

    logic         hold;
    logic [W-1:0] h_s;
    logic         h_c;
    logic [1:0]   h_id;
    exp_t         m_e;
    logic [W:0]   m_full;

    adder_share_arb #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    // Monitor: samples 2ns after negedge; inputs move at +1, tasks look at +3.
    always @(negedge clk) begin
        #2;
        hs_mask = '0;
        if (!rst_n) begin
            exp_q.delete();
            hold = 1'b0;
            n_cmp++;
            if (rsp_valid !== 1'b0 || req_ready !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: rsp_valid=%b req_ready=%b, required 0/0000",
                         rsp_valid, req_ready);
            end
        end else begin
            n_cmp++;
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
                n_fail++;
                $display("FAIL ready_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
            end
            hs_mask = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (hs_mask[i]) begin
                    m_full = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]};
                    m_e.s  = m_full[W-1:0];
                    m_e.c  = m_full[W];
                    m_e.id = 2'(i);
                    exp_q.push_back(m_e);
                    grant_log.push_back(i);
                end
            end
            if (hold) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_sum !== h_s || rsp_cout !== h_c || rsp_id !== h_id) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b %h/%b/%0d, required 1 %h/%b/%0d",
                             rsp_valid, rsp_sum, rsp_cout, rsp_id, h_s, h_c, h_id);
                end
            end
            if (rsp_valid === 1'b1 && rsp_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: got %h/%b/%0d, required none",
                             rsp_sum, rsp_cout, rsp_id);
                end else begin
                    m_e = exp_q.pop_front();
                    if (rsp_sum !== m_e.s || rsp_cout !== m_e.c || rsp_id !== m_e.id) begin
                        n_fail++;
                        $display("FAIL scoreboard: got %h/%b/%0d, required %h/%b/%0d",
                                 rsp_sum, rsp_cout, rsp_id, m_e.s, m_e.c, m_e.id);
                    end
                end
            end
            hold = (rsp_valid === 1'b1) && !rsp_ready;
            h_s  = rsp_sum;
            h_c  = rsp_cout;
            h_id = rsp_id;
        end
    end

    // Advance to the drive point of the next cycle; fresh operands for
    // requesters whose last word was accepted.
    task automatic cyc();
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_mask[i]) begin
                req_a[i*W +: W] = $urandom;
                req_b[i*W +: W] = $urandom;
            end
        end
    endtask

    task automatic send(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        got = 1'b0;
        cyc();
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid[idx]    = 1'b1;
        for (int t = 0; t < 10 && !got; t++) begin
            #2;
            if (req_ready[idx]) got = 1'b1;
            else cyc();
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL send_timeout: req %0d ready never seen, required within 10 cycles", idx);
        end
        cyc();
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 6 && !got; t++) begin
            #2;
            if (rsp_valid === 1'b1) got = 1'b1;
            else cyc();
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=0, required 1 within 6 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #2;
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid);
            end
            n_cmp++;
            if (req_ready !== '0) begin
                n_fail++;
                $display("FAIL reset_req_ready: got %b, required 0000", req_ready);
            end
        end
        cyc();
        req_valid = '0;
        rst_n     = 1'b1;
        cyc();
    endtask

    task automatic test_fairness();
        logic [N-1:0] e;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k == 0) req_valid = '1;
            #2;
            e = '0;
            e[k % N] = 1'b1;
            n_cmp++;
            if (req_ready !== e) begin
                n_fail++;
                $display("FAIL fair_grant[%0d]: got %b, required %b", k, req_ready, e);
            end
            n_cmp++;
            if (rsp_valid !== (k >= LAT)) begin
                n_fail++;
                $display("FAIL fair_latency[%0d]: rsp_valid=%b, required %b", k, rsp_valid, k >= LAT);
            end
            if (k >= LAT) begin
                n_cmp++;
                if (rsp_id !== 2'((k - LAT) % N)) begin
                    n_fail++;
                    $display("FAIL fair_id[%0d]: got %0d, required %0d", k, rsp_id, (k - LAT) % N);
                end
            end
        end
        cyc();
        req_valid = '0;
        repeat (3) cyc();
    endtask

    task automatic test_overflow();
        rsp_ready = 1'b1;
        send(1, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_rsp();
        n_cmp++;
        if (rsp_sum !== 32'h0000_0000 || rsp_cout !== 1'b1 || rsp_id !== 2'd1) begin
            n_fail++;
            $display("FAIL ovf_wrap: got %h/%b/%0d, required 00000000/1/1", rsp_sum, rsp_cout, rsp_id);
        end
        send(3, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_rsp();
        n_cmp++;
        if (rsp_sum !== 32'h8000_0000 || rsp_cout !== 1'b0 || rsp_id !== 2'd3) begin
            n_fail++;
            $display("FAIL ovf_sign: got %h/%b/%0d, required 80000000/0/3", rsp_sum, rsp_cout, rsp_id);
        end
        send(0, 32'h1234_5678, 32'h8765_4321);
        wait_rsp();
        n_cmp++;
        if (rsp_sum !== 32'h9999_9999 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
            n_fail++;
            $display("FAIL add_plain: got %h/%b/%0d, required 99999999/0/0", rsp_sum, rsp_cout, rsp_id);
        end
        repeat (3) cyc();
    endtask

    task automatic test_backpressure();
        int           last;
        logic [W-1:0] s_s;
        logic         s_c;
        logic [1:0]   s_id;
        logic [N-1:0] e;
        rsp_ready = 1'b1;
        cyc();
        req_valid = '1;
        repeat (3) cyc();
        cyc();
        rsp_ready = 1'b0;
        #2;
        last = grant_log[$];
        s_s  = rsp_sum;
        s_c  = rsp_cout;
        s_id = rsp_id;
        n_cmp++;
        if (rsp_valid !== 1'b1 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL bp_enter: rsp_valid=%b req_ready=%b, required 1/0000", rsp_valid, req_ready);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            #2;
            n_cmp++;
            if (req_ready !== '0 || rsp_valid !== 1'b1 || rsp_sum !== s_s ||
                rsp_cout !== s_c || rsp_id !== s_id) begin
                n_fail++;
                $display("FAIL bp_frozen[%0d]: rdy=%b v=%b %h/%b/%0d, required 0000 1 %h/%b/%0d",
                         k, req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, s_s, s_c, s_id);
            end
        end
        cyc();
        rsp_ready = 1'b1;
        #2;
        e = '0;
        e[(last + 1) % N] = 1'b1;
        n_cmp++;
        if (req_ready !== e) begin
            n_fail++;
            $display("FAIL bp_resume_ptr: got %b, required %b", req_ready, e);
        end
        repeat (3) cyc();
        cyc();
        req_valid = '0;
        repeat (4) cyc();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_sparse();
        rsp_ready = 1'b1;
        send(2, $urandom, $urandom);
        req_valid = 4'b1010;
        #2;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL sparse_first: got %b, required 1000", req_ready);
        end
        cyc();
        req_valid = 4'b0010;
        #2;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL sparse_second: got %b, required 0010", req_ready);
        end
        cyc();
        req_valid = '0;
        repeat (3) cyc();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        send(1, $urandom, $urandom);
        #2;
        n_cmp++;
        if (rsp_valid !== 1'b1 && LAT == 1) begin
            n_fail++;
            $display("FAIL mid_pending: rsp_valid=%b, required 1", rsp_valid);
        end
        cyc();
        rst_n     = 1'b0;
        req_valid = '1;
        #2;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_clear: rsp_valid=%b, required 0", rsp_valid);
        end
        cyc();
        cyc();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #2;
        n_cmp++;
        if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: rdy=%b v=%b, required 0001/0", req_ready, rsp_valid);
        end
        repeat (3) cyc();
        cyc();
        req_valid = '0;
        repeat (4) cyc();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        hold      = 1'b0;
        hs_mask   = '0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = $urandom;
            req_b[i*W +: W] = $urandom;
        end
        test_reset();
        test_fairness();
        test_overflow();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
